// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_responder: multi-cycle load/store target with Stall/Done handshake |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          count_q, count_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                is_wr_q, is_wr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                req_any;
  logic                req_legal;
  logic                unused_addr;

  logic [DATA_W-1:0]   mem [2**MEM_AW];

  assign req_any     = Rd | Wr;
  assign req_legal   = (Rd ^ Wr) & ~Addr[0];
  // Word index wraps: address bits above the array depth are don't-care.
  assign unused_addr = ^Addr[ADDR_W-1:MEM_AW+1];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    is_wr_d = is_wr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_legal) begin
          idx_d   = Addr[MEM_AW:1];
          wdata_d = DataIn;
          is_wr_d = Wr;
          count_d = COUNT_INIT;
          state_d = BUSY;
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (is_wr_q) mem_we = 1'b1;
          else         rdata_d = mem[idx_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_wr_q <= is_wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array survives reset; an aborted write never reaches it.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[idx_q] <= wdata_q;
  end

  assign Stall   = (state_q == BUSY) | req_legal;
  assign DataOut = rdata_q;
  assign Done    = done_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_mem_responder: vector table + scoreboard bench for the responder    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;

  localparam int LAT = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_err;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, err;
  logic [15:0] Addr1, DataIn1, DataOut1;
  logic        Rd1, Wr1, Done1, Stall1, err1;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] last_rd;
  sb_t         sb[$];
  sb_t         mon_rec;
  vec_t        vecs[13];

  data_mem_responder #(.DATA_W(16), .ADDR_W(16), .MEM_AW(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(16), .MEM_AW(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .Addr(Addr1), .DataIn(DataIn1), .Rd(Rd1), .Wr(Wr1),
    .DataOut(DataOut1), .Done(Done1), .Stall(Stall1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every Done consumes one accepted access; reads compare data.
  always @(negedge clk) begin
    if (rst && Done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        mon_rec = sb.pop_front();
        if (mon_rec.is_rd) check("sb_read_data", {16'h0, DataOut}, {16'h0, mon_rec.data});
      end
    end
    if (Done && err) begin
      checks++;
      errors++;
      $display("FAIL done_err_overlap: got Done=1 err=1 expected not both (cycle %0d)", cyc);
    end
  end

  task automatic do_access(input vec_t v);
    int  n;
    bit  legal;
    legal = !v.exp_err;
    @(negedge clk);
    Rd = v.rd; Wr = v.wr; Addr = v.addr; DataIn = v.din;
    #1;
    check("stall_on_request", {31'h0, Stall}, {31'h0, legal});
    if (legal) sb.push_back('{v.rd, v.exp});
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'($urandom); DataIn = 16'($urandom);
    if (!legal) begin
      @(negedge clk);
      check("err_pulse", {31'h0, err}, 32'h1);
      check("err_stall", {31'h0, Stall}, 32'h0);
      check("err_no_done", {31'h0, Done}, 32'h0);
      @(negedge clk);
      check("err_one_cycle", {31'h0, err}, 32'h0);
    end else begin
      n = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (Done) begin
          n = k;
          break;
        end
        check("stall_busy", {31'h0, Stall}, 32'h1);
      end
      check("done_latency", 32'(n - 1), LAT);
      if (n != 0) begin
        check("stall_done_cycle", {31'h0, Stall}, 32'h0);
        if (v.wr) check("write_keeps_dataout", {16'h0, DataOut}, {16'h0, last_rd});
        else      last_rd = v.exp;
        @(negedge clk);
        check("done_one_cycle", {31'h0, Done}, 32'h0);
      end
    end
  endtask

  initial begin
    int nd;
    int last_done;
    rst = 1'b0;
    Rd = 0; Wr = 0; Addr = 0; DataIn = 0;
    Rd1 = 0; Wr1 = 0; Addr1 = 0; DataIn1 = 0;
    last_rd = 16'h0000;

    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h0011, 16'hDEAD, 1'b1, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1111};
    vecs[7]  = '{1'b0, 1'b1, 16'h0030, 16'h5A5A, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 16'h0812, 16'hCAFE, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 16'hCAFE};
    vecs[10] = '{1'b0, 1'b1, 16'h07FE, 16'h7777, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h7777};
    vecs[12] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'h0, Done}, 32'h0);
    check("rst_stall", {31'h0, Stall}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_dataout", {16'h0, DataOut}, 32'h0);
    check("rst_dataout_l1", {16'h0, DataOut1}, 32'h0);
    check("rst_done_l1", {31'h0, Done1}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) do_access(vecs[i]);

    // Write aborted by reset in its second busy cycle
    @(negedge clk);
    Wr = 1'b1; Addr = 16'h0030; DataIn = 16'h1234;
    @(posedge clk);
    #1 Wr = 1'b0;
    @(negedge clk);
    check("abort_busy1_stall", {31'h0, Stall}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_stall", {31'h0, Stall}, 32'h0);
    check("abort_done", {31'h0, Done}, 32'h0);
    check("abort_dataout", {16'h0, DataOut}, 32'h0);
    rst = 1'b1;
    last_rd = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_no_done", {31'h0, Done}, 32'h0);
    end
    do_access('{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h5A5A});

    // Rd held continuously: back-to-back reads
    for (int k = 0; k < 3; k++) sb.push_back('{1'b1, 16'hBEEF});
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0010;
    nd = 0;
    last_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Done) begin
        nd++;
        if (nd > 1) check("b2b_spacing", 32'(cyc - last_done), LAT + 1);
        last_done = cyc;
        if (nd == 3) begin
          Rd = 1'b0;
          break;
        end
      end else if (nd >= 1) begin
        check("b2b_dataout_stable", {16'h0, DataOut}, 32'hBEEF);
      end
    end
    check("b2b_done_count", nd, 3);
    repeat (LAT + 3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    // LATENCY=1 instance: write then back-to-back read
    @(negedge clk);
    Wr1 = 1'b1; Addr1 = 16'h0040; DataIn1 = 16'h00A5;
    #1 check("l1_stall_req", {31'h0, Stall1}, 32'h1);
    @(posedge clk);
    #1 begin Wr1 = 1'b0; DataIn1 = 16'hFFFF; end
    @(negedge clk);
    check("l1_wr_busy_done", {31'h0, Done1}, 32'h0);
    check("l1_wr_busy_stall", {31'h0, Stall1}, 32'h1);
    @(negedge clk);
    check("l1_wr_done", {31'h0, Done1}, 32'h1);
    check("l1_wr_dataout", {16'h0, DataOut1}, 32'h0);
    Rd1 = 1'b1; Addr1 = 16'h0040;
    #1 check("l1_rd_stall_req", {31'h0, Stall1}, 32'h1);
    @(posedge clk);
    #1 Rd1 = 1'b0;
    @(negedge clk);
    check("l1_rd_busy_done", {31'h0, Done1}, 32'h0);
    @(negedge clk);
    check("l1_rd_done", {31'h0, Done1}, 32'h1);
    check("l1_rd_data", {16'h0, DataOut1}, 32'h00A5);
    @(negedge clk);
    check("l1_done_one_cycle", {31'h0, Done1}, 32'h0);
    check("l1_data_held", {16'h0, DataOut1}, 32'h00A5);
    check("l1_no_err", {31'h0, err1}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
